// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC widths, arctangent table, FSM states and angle constants
package cordic_pkg;

  localparam int W_IN    = 19;
  localparam int W_Z     = 9;
  localparam int N_ITER  = 8;
  localparam int ANG_180 = 256;

  // Binary-angle arctangents (512 units per turn); element 0 is atan(2^0).
  localparam logic [N_ITER-1:0][W_Z-1:0] ATAN_TAB = {
    9'd1, 9'd1, 9'd3, 9'd5, 9'd10, 9'd20, 9'd38, 9'd64
  };

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } cordic_state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational arctangent lookup by micro-rotation index
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [2:0]     idx_i,
  output logic [W_Z-1:0] atan_o
);

  assign atan_o = ATAN_TAB[idx_i];

endmodule

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC returning angle and scaled magnitude
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int W_IN   = cordic_pkg::W_IN,
  parameter int W_Z    = cordic_pkg::W_Z,
  parameter int N_ITER = cordic_pkg::N_ITER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W_IN-1:0] in_x,
  input  logic signed [W_IN-1:0] in_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W_Z-1:0]  out_z,
  output logic signed [W_IN+1:0] out_mag,
  output logic                   out_zero
);

  localparam int W = W_IN + 2;
  localparam logic [2:0] LAST = 3'(N_ITER - 1);

  cordic_state_e state_q, state_d;
  logic signed [W-1:0]   x_q, x_d, y_q, y_d;
  logic signed [W_Z-1:0] z_q, z_d;
  logic [2:0]            i_q, i_d;
  logic                  zero_q, zero_d;
  logic signed [W_Z-1:0] out_z_q, out_z_d;
  logic signed [W-1:0]   out_mag_q, out_mag_d;
  logic                  out_zero_q, out_zero_d;

  logic [W_Z-1:0]        atan;
  logic signed [W-1:0]   ext_x, ext_y, x_sh, y_sh, x_it, y_it;
  logic signed [W_Z-1:0] z_it;

  cordic_atan_rom u_atan_rom (
    .idx_i  (i_q),
    .atan_o (atan)
  );

  assign ext_x = {{2{in_x[W_IN-1]}}, in_x};
  assign ext_y = {{2{in_y[W_IN-1]}}, in_y};

  // One micro-rotation from the current register values; x and y both use pre-update operands.
  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;
  assign x_it = y_q[W-1] ? (x_q - y_sh) : (x_q + y_sh);
  assign y_it = y_q[W-1] ? (y_q + x_sh) : (y_q - x_sh);
  assign z_it = y_q[W-1] ? (z_q - $signed(W_Z'(atan))) : (z_q + $signed(W_Z'(atan)));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    i_d        = i_q;
    zero_d     = zero_q;
    out_z_d    = out_z_q;
    out_mag_d  = out_mag_q;
    out_zero_d = out_zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Left half-plane vectors are flipped by 180 degrees so the iterations converge.
          if (in_x[W_IN-1]) begin
            x_d = -ext_x;
            y_d = -ext_y;
            z_d = W_Z'(ANG_180);
          end else begin
            x_d = ext_x;
            y_d = ext_y;
            z_d = '0;
          end
          i_d     = '0;
          zero_d  = (in_x == '0) && (in_y == '0);
          state_d = ITER;
        end
      end
      ITER: begin
        x_d = x_it;
        y_d = y_it;
        z_d = z_it;
        i_d = i_q + 3'd1;
        if (i_q == LAST) begin
          state_d    = DONE;
          out_z_d    = zero_q ? '0 : z_it;
          out_mag_d  = zero_q ? '0 : x_it;
          out_zero_d = zero_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      i_q        <= '0;
      zero_q     <= 1'b0;
      out_z_q    <= '0;
      out_mag_q  <= '0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      i_q        <= i_d;
      zero_q     <= zero_d;
      out_z_q    <= out_z_d;
      out_mag_q  <= out_mag_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_z     = out_z_q;
  assign out_mag   = out_mag_q;
  assign out_zero  = out_zero_q;

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative vectoring-mode CORDIC: accepts one signed (x, y) vector and returns its angle as a 9-bit binary angle, plus its CORDIC-scaled magnitude. This is the counterpart of the rotation-mode vertex stages. Rotation stages turn vectors by a given angle; this block recovers the angle a vector makes with +x. It sits in the shape-setup path and produces the z values the rotation pipeline consumes. It reuses the same 8-step arctangent sequence and angle format, so round trips are consistent.

## Interface
- W_IN, default 19: input coordinate width, signed.
- W_Z, default 9: angle width, signed binary angle (512 units = 360°).
- N_ITER, default 8: micro-rotations; iteration index width is 3.

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  **synchronous, active-high reset**
- in_valid  in  1  input vector present
- in_ready  out  1  high only in IDLE
- in_x  in  W_IN  signed x
- in_y  in  W_IN  signed y
- out_valid  out  1  result present (DONE)
- out_ready  in  1  downstream accepts result
- out_z  out  W_Z  signed angle, atan2(y,x) in 512/turn units
- out_mag  out  W_IN+2  signed, ≈1.6468·|v|, always ≥0
- out_zero  out  1  input was (0,0)

## Operation
- FSM states are IDLE, ITER and DONE; reset returns to IDLE.
- IDLE → ITER on in_valid && in_ready.
  - Capture and sign-extend in_x and in_y to W_IN+2 bits; set i=0.
  - Pre-rotation: if in_x<0, load x=−in_x, y=−in_y, z=256 (wraps to −256, i.e. 180°). Otherwise load x=in_x, y=in_y, z=0.
  - Set the zero flag = (in_x==0 && in_y==0).
- ITER: one micro-rotation per cycle, using arithmetic shifts (>>>) and the atan table entry for i.
  - If y≥0: x+=y>>>i, y−=x>>>i, z+=atan[i].
  - Else: x−=y>>>i, y+=x>>>i, z−=atan[i].
  - Both x and y updates use the pre-update values.
  - z wraps modulo 512; there is no saturation.
  - i increments each cycle. After i==N_ITER−1 the FSM goes to DONE.
- atan table, in 512/turn units: 64, 38, 20, 10, 5, 3, 1, 1.
- DONE:
  - out_valid=1; out_z=z, out_mag=x.
  - If the zero flag is set, out_z=0, out_mag=0 and out_zero=1 instead.
  - Outputs hold stable until out_ready. On out_valid && out_ready, go to IDLE.
- The internal W_IN+2 width guarantees no overflow for any input, including −2^18.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_z=0, out_mag=0, out_zero=0, i=0.

## Timing
- Accept at edge k. Iterations run at edges k+1…k+8. DONE is entered at edge k+8, so out_valid is visible 8 cycles after the accepting edge.
- Earliest next accept is one cycle after the output handshake. Throughput is 1 vector per 10 cycles with out_ready held high.
- in_ready is low throughout ITER and DONE. in_valid arriving then is ignored, not queued.
- in_x and in_y matter only on the accepting edge.
- Output registers change only on entry to DONE. They are not cleared on leaving DONE; out_valid alone qualifies them.
- Reset asserted mid-ITER or mid-DONE: next cycle is IDLE with out_valid=0 and the pending result discarded. Reset dominates a simultaneous handshake.

## Structure
- Package cordic_pkg holds:
  - W_IN, W_Z and N_ITER defaults
  - the atan constant table
  - an FSM state enum (IDLE, ITER, DONE)
  - the angle constant ANG_180 = 256
- The rotation-mode stages use the same package.
- Sub-module cordic_atan_rom: combinational, index in (3 bits) → atan out (W_Z bits). It is shared with the rotation-path angle sequencer.
- The FSM and datapath live in the top level, about 150–200 lines.

## Test plan
- (100, 0), out_ready=1 → out_valid exactly 8 cycles after accept; out_z=0, out_mag=166, out_zero=0.
- (−100, 0) → out_z=−256, out_mag=166. Then (0, 100) → out_z=128±2. Then (0, −100) → out_z=−128±2.
- (0, 0) → out_zero=1, out_z=0, out_mag=0.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new data:
  - Outputs stay unchanged and in_ready stays 0.
  - After out_ready=1, in_ready=1 the next cycle.
  - The next accepted vector is the one presented then, not a stale one.
- Extremes (−2^18, −2^18) and (2^18−1, −2^18): no wrap in out_mag; out_z=−192±2 (−135°) and −64±2 (−45°) respectively.
- Assert reset at iteration 4 → next cycle in_ready=1, out_valid=0, and no output for that vector. A new vector then completes normally.
